// File: rtl/program_loader.sv
// program_loader: boot-time image loader.
// Takes a byte stream (32-bit little-endian word count, then that many
// little-endian data words), writes each word to main memory and holds the
// CPU in reset until the whole image has landed.
// Optional build macro LOADER_CHECKSUM_EN: after the data, a 32-bit
// little-endian checksum (sum of all data words mod 2^32) is received and
// compared; a mismatch ends in ERROR instead of DONE.
module program_loader #(
  parameter int          DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MAX_N = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  bcnt;      // byte position within the current word
  logic [23:0] shreg;     // bytes 0..2 of the word being assembled
  logic [31:0] wcnt;      // words written so far in this load
  logic [31:0] n;         // latched word count from the header
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;      // running sum of written words
`endif

  logic        accept;
  logic        word_done;
  logic [31:0] word;
  logic [31:0] wcnt_nxt;
  logic        restart;

  assign accept    = byte_valid && byte_ready;
  assign word_done = accept && (bcnt == 2'd3);
  // Incoming byte is the top byte once three earlier bytes sit in shreg.
  assign word      = {byte_data, shreg};
  assign wcnt_nxt  = wcnt + 32'd1;
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt         = state;
    byte_ready        = 1'b0;
    mem_write_enable  = 1'b0;
    mem_write_address = 32'd0;
    cpu_hold          = 1'b1;
    busy              = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_done) begin
          if (word == 32'd0)
`ifdef LOADER_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
`endif
          else if (word > MAX_N) state_nxt = S_ERROR;
          else                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_done) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy              = 1'b1;
        mem_write_enable  = 1'b1;
        mem_write_address = BASE_ADDR + wcnt;
        if (wcnt_nxt == n)
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        else
          state_nxt = S_DATA;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nxt = S_COUNT;
      end
      S_ERROR: begin
        err = 1'b1;
        if (start) state_nxt = S_COUNT;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready = 1'b1;
        if (word_done) state_nxt = (word == csum) ? S_DONE : S_ERROR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly, header latch, write data register and word counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt           <= 2'd0;
      shreg          <= 24'd0;
      wcnt           <= 32'd0;
      n              <= 32'd0;
      mem_write_data <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum           <= 32'd0;
`endif
    end else begin
      if (restart) begin
        bcnt  <= 2'd0;
        shreg <= 24'd0;
        wcnt  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
        csum  <= 32'd0;
`endif
      end
      if (accept) begin
        shreg <= word[31:8];
        bcnt  <= bcnt + 2'd1;
      end
      if (state == S_COUNT && word_done) begin
        n    <= word;
        wcnt <= 32'd0;
      end
      if (state == S_DATA && word_done) mem_write_data <= word;
      if (state == S_WRITE) begin
        wcnt <= wcnt_nxt;
`ifdef LOADER_CHECKSUM_EN
        csum <= csum + mem_write_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: loads are issued as byte streams, the
// expected memory writes are queued from a simple model, and a monitor pops
// and compares on every write strobe.
module tb_program_loader;
  localparam int          DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        cpu_hold, busy, done, err;

  program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard and last one cycle.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (rst && mem_write_enable) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none",
                 mem_write_address, mem_write_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", mem_write_address, e.a);
        chk("wr_data", mem_write_data, e.d);
        chk("wr_no_ready", {31'd0, byte_ready}, 32'd0);
      end
      chk("wr_one_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_write_enable;
  end

  // Present one byte (called at a negedge) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL byte_timeout actual byte_ready=0 required 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = $urandom;
    if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] x;
    x = w;
    for (int k = 0; k < 4; k++) send_byte(x[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_status(input bit exp_done);
    int t;
    t = 0;
    while (!done && !err && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL finish_timeout actual done=0 err=0 required completion");
    end
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("err", {31'd0, err}, {31'd0, !exp_done});
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("ready_end", {31'd0, byte_ready}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  // Reference: header n; if n <= DEPTH, words i land at BASE+i, then done.
  // With the checksum build, the sum follows and must match for done.
  task automatic run_load(input logic [31:0] n, input logic [31:0] words[$],
                          input int gap, input bit corrupt);
    bit exp_done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum;
    sum = 32'd0;
`endif
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    send_word(n, gap);
    exp_done = (n <= 32'(DEPTH));
    if (exp_done) begin
      for (int i = 0; i < int'(n); i++) begin
`ifdef LOADER_CHECKSUM_EN
        sum += words[i];
`endif
        sb.push_back('{a: BASE + 32'(i), d: words[i]});
        send_word(words[i], gap);
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(corrupt ? (sum ^ 32'h0000_0100) : sum, gap);
      exp_done = !corrupt;
`endif
    end
    wait_status(exp_done);
  endtask

  logic [31:0] basic[$];
  logic [31:0] big[$];
  logic [31:0] rnd[$];
  logic [31:0] empty_q[$];

  initial begin
    basic = '{32'h1234_5678, 32'hDEAD_BEEF};
    // Reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
    chk("rst_addr", mem_write_address, 32'd0);
    chk("rst_data", mem_write_data, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    run_load(32'd2, basic, 0, 1'b0);          // basic
    run_load(32'd2, basic, 1, 1'b0);          // alternating gaps
    run_load(32'd0, empty_q, 0, 1'b0);        // empty image
    run_load(32'h801, empty_q, 0, 1'b0);      // over depth

    // Mid-load reset after 5 data bytes: first word written, rest discarded.
    pulse_start();
    send_word(32'd2, 0);
    sb.push_back('{a: BASE, d: 32'h1122_3344});
    send_word(32'h1122_3344, 0);
    send_byte(8'hAA, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, byte_ready}, 32'd0);
    chk("mr_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_err", {31'd0, err}, 32'd0);
    chk("mr_sb_empty", sb.size(), 32'd0);
    run_load(32'd2, basic, 0, 1'b0);

    // Full-depth image
    for (int i = 0; i < DEPTH; i++) big.push_back($urandom);
    run_load(32'(DEPTH), big, 0, 1'b0);

    // Checksum corruption (plain build: ordinary reload)
    run_load(32'd2, basic, 0, 1'b1);

    // Random short loads with random gaps
    for (int r = 0; r < 8; r++) begin
      int nn;
      nn = $urandom_range(1, 6);
      rnd.delete();
      for (int i = 0; i < nn; i++) rnd.push_back($urandom);
      run_load(32'(nn), rnd, 2, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
